// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with prescaler, load/clear, wrap or saturate
module updown_mod_counter #(
  parameter int WIDTH    = 23,
  parameter int MAX      = 2**WIDTH-1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             ovf_seen
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MAX);
  localparam logic [PW-1:0]    LAST_P = PW'(PRESCALE-1);

  logic [PW-1:0]    p;
  logic             tick;
  logic [WIDTH-1:0] load_clamped;

  assign tick         = en && (p == LAST_P);
  assign load_clamped = (load_val > MAXV) ? MAXV : load_val;
  assign tc           = dir ? (q == MAXV) : (q == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q        <= '0;
      p        <= '0;
      ovf      <= 1'b0;
      ovf_seen <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (en)
        p <= tick ? '0 : p + PW'(1);
      // load restarts the prescale period and suppresses any coincident step
      if (load) begin
        q <= load_clamped;
        p <= '0;
      end else if (tick) begin
        if (dir) begin
          if (q < MAXV) begin
            q <= q + WIDTH'(1);
          end else begin
            q        <= (SATURATE != 0) ? MAXV : '0;
            ovf      <= 1'b1;
            ovf_seen <= 1'b1;
          end
        end else begin
          if (q > '0) begin
            q <= q - WIDTH'(1);
          end else begin
            q        <= (SATURATE != 0) ? '0 : MAXV;
            ovf      <= 1'b1;
            ovf_seen <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - checks two counter configurations against a behavioural model
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, clr, load;
  logic [3:0] load_val;
  logic [3:0] qa, qb;
  logic       tca, tcb, ovfa, ovfb, seena, seenb;

  int checks = 0;
  int errors = 0;

  int mq[2], mp[2], movf[2], mseen[2];
  int ps_of[2]  = '{3, 1};
  int sat_of[2] = '{0, 1};

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .q(qa), .tc(tca), .ovf(ovfa), .ovf_seen(seena));

  updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .q(qb), .tc(tcb), .ovf(ovfb), .ovf_seen(seenb));

  // Count range is 0..9; arithmetic done on plain integers
  task automatic model_update(input int i);
    bit t;
    int nq, nov;
    if (rst || clr) begin
      mq[i] = 0; mp[i] = 0; movf[i] = 0; mseen[i] = 0;
      return;
    end
    t   = en && (mp[i] == ps_of[i] - 1);
    nov = 0;
    nq  = mq[i];
    if (en) mp[i] = t ? 0 : mp[i] + 1;
    if (load) begin
      nq    = (int'(load_val) > 9) ? 9 : int'(load_val);
      mp[i] = 0;
    end else if (t) begin
      if (dir) begin
        if (mq[i] < 9) nq = mq[i] + 1;
        else begin nov = 1; nq = sat_of[i] ? 9 : 0; end
      end else begin
        if (mq[i] > 0) nq = mq[i] - 1;
        else begin nov = 1; nq = sat_of[i] ? 0 : 9; end
      end
    end
    mq[i]   = nq;
    movf[i] = nov;
    if (nov) mseen[i] = 1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int etc_a, etc_b;
    etc_a = dir ? (mq[0] == 9) : (mq[0] == 0);
    etc_b = dir ? (mq[1] == 9) : (mq[1] == 0);
    chk("a_q",    int'(qa),    mq[0]);
    chk("a_tc",   int'(tca),   etc_a);
    chk("a_ovf",  int'(ovfa),  movf[0]);
    chk("a_seen", int'(seena), mseen[0]);
    chk("b_q",    int'(qb),    mq[1]);
    chk("b_tc",   int'(tcb),   etc_b);
    chk("b_ovf",  int'(ovfb),  movf[1]);
    chk("b_seen", int'(seenb), mseen[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst = 1; en = 0; dir = 0; clr = 0; load = 0; load_val = 0;
    mq = '{0, 0}; mp = '{0, 0}; movf = '{0, 0}; mseen = '{0, 0};
    cyc();
    chk("reset_q", int'(qa), 0);
    chk("reset_tc_down", int'(tca), 1);

    // count up through wrap
    rst = 0; en = 1; dir = 1;
    run(36);
    chk("up_seen", int'(seena), 1);

    // count down from reset
    rst = 1; cyc();
    rst = 0; dir = 0;
    run(30);

    // clamped load, then load coincident with a tick
    load = 1; load_val = 13; cyc();
    chk("load_clamp", int'(qa), 9);
    load = 0; run(2);
    load = 1; load_val = 4; cyc();
    chk("load_no_step", int'(qa), 4);
    load = 0; dir = 1; run(7);

    // clr beats load
    clr = 1; load = 1; load_val = 7; cyc();
    chk("clr_wins_q", int'(qa), 0);
    chk("clr_wins_seen", int'(seena), 0);
    clr = 0; load = 0; run(4);

    // rst with clr and en, first step three cycles later
    rst = 1; clr = 1; cyc();
    rst = 0; clr = 0; run(2);
    chk("rst_no_early_step", int'(qa), 0);
    cyc();
    chk("rst_first_step", int'(qa), 1);

    // en gaps freeze the prescaler
    rst = 1; cyc();
    rst = 0;
    en = 1; cyc();
    en = 0; cyc(); cyc();
    chk("en_hold", int'(qa), 0);
    en = 1; cyc();
    chk("en_pre_step", int'(qa), 0);
    cyc();
    chk("en_step", int'(qa), 1);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom_range(63) == 0);
      clr      = ($urandom_range(31) == 0);
      load     = ($urandom_range(15) == 0);
      load_val = 4'($urandom_range(15));
      en       = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) dir = ~dir;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
